// File: rtl/skintone_pkg.sv
// Shared pixel and feeder-state types for the skintone pixel pipeline.
// Used by pixel_frame_feeder, pixel_skid_fifo and skintone_datapath.
package skintone_pkg;

    localparam int PIX_W = 24;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel FIFO with a registered head, so the head drives the output directly.
// A write together with a pop is accepted in every occupancy state that can reach it.
module pixel_skid_fifo
    import skintone_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  pixel_t     wr_data,
    input  logic       rd_en,
    output logic [1:0] count,
    output pixel_t     head
);

    pixel_t     r_head;
    pixel_t     r_tail;
    logic [1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (wr_en) begin
                        r_head  <= wr_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (wr_en && rd_en) begin
                        r_head <= wr_data;
                    end else if (wr_en) begin
                        r_tail  <= wr_data;
                        r_count <= 2'd2;
                    end else if (rd_en) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a write is only ever offered alongside a pop.
                    if (rd_en) begin
                        r_head <= r_tail;
                        if (wr_en) begin
                            r_tail <= wr_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_head;

endmodule

// File: rtl/pixel_frame_feeder.sv
// Reads a frame of pixels from a synchronous-read RAM and streams them out with backpressure.
// Optional macro FEEDER_STALL_STATS_EN adds the stall_count statistics output.
module pixel_frame_feeder
    import skintone_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_len,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              pixel_dataout_valid,
    input  logic              pixel_dataout_ready,
`ifdef FEEDER_STALL_STATS_EN
    output logic [31:0]       stall_count,
`endif
    output feeder_state_t     dbg_state
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    feeder_state_t     r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_issued;
    logic              r_inflight;

    logic [1:0] w_count;
    pixel_t     w_head;
    logic       w_valid;
    logic       w_pop;
    logic [2:0] w_slots;
    logic       w_issue;
    logic       w_last_issue;
    logic       w_last_pop;
    logic       w_accept;

    // Handshake: a pixel moves when valid and ready are both high at a rising edge;
    // once valid rises, the head register (and so pixel_dataout) holds until that edge.
    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && pixel_dataout_ready;

    // Credit check counts a pop this cycle as a freed slot, giving one pixel per cycle.
    assign w_slots      = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == RUN) && (w_slots < 3'd2);
    assign w_last_issue = w_issue && (r_issued == r_len - ONE);
    assign w_last_pop   = (r_state == DRAIN) && w_pop && (w_count == 2'd1) && !r_inflight;
    assign w_accept     = (r_state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_len    <= '0;
            r_issued <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base   <= base_addr;
                        r_len    <= frame_len;
                        r_issued <= '0;
                        r_state  <= (frame_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_issued <= r_issued + ONE;
                    end
                    if (w_last_issue) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    pixel_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_inflight),
        .wr_data (mem_rd_data),
        .rd_en   (w_pop),
        .count   (w_count),
        .head    (w_head)
    );

`ifdef FEEDER_STALL_STATS_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_accept) begin
            r_stall <= '0;
        end else if (w_valid && !pixel_dataout_ready && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_count = r_stall;
`endif

    assign busy                = (r_state != IDLE);
    assign done                = (r_state == DONE);
    assign mem_rd_en           = w_issue;
    assign mem_rd_addr         = r_base + r_issued;
    assign pixel_dataout       = w_head;
    assign pixel_dataout_valid = w_valid;
    assign dbg_state           = r_state;

endmodule

// File: tb/tb_pixel_frame_feeder.sv
// Directed bench for pixel_frame_feeder: RAM model, ready driver, scoreboard and frame scenarios.
// Stall statistics are also checked when FEEDER_STALL_STATS_EN is defined.
module tb_pixel_frame_feeder;
    import skintone_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   base_addr;
    logic [15:0]   frame_len;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [15:0]   mem_rd_addr;
    logic [23:0]   mem_rd_data = '0;
    logic [23:0]   pixel_dataout;
    logic          pixel_dataout_valid;
    logic          pixel_dataout_ready;
    feeder_state_t dbg_state;
`ifdef FEEDER_STALL_STATS_EN
    logic [31:0]   stall_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[$];
    logic [15:0] exp_addr_q[$];

    int   cyc = 0;
    int   outstanding = 0;
    int   accepted = 0;
    int   done_cnt = 0;
    int   first_valid_cyc = -1;
    int   last_xfer_cyc = 0;
    int   start_cyc = 0;
    int   stall_exp = 0;
    int   ready_mode = 0;
    logic prev_stall = 1'b0;
    logic [23:0] prev_data = '0;

    pixel_frame_feeder #(.ADDR_W(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .base_addr           (base_addr),
        .frame_len           (frame_len),
        .busy                (busy),
        .done                (done),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_data         (mem_rd_data),
        .pixel_dataout       (pixel_dataout),
        .pixel_dataout_valid (pixel_dataout_valid),
        .pixel_dataout_ready (pixel_dataout_ready),
`ifdef FEEDER_STALL_STATS_EN
        .stall_count         (stall_count),
`endif
        .dbg_state           (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [23:0] ram_val(input logic [15:0] a);
        return {8'h00, a};
    endfunction

    // Synchronous-read RAM: data valid one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram_val(mem_rd_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ready driver: mode 0 holds ready high, mode 1 toggles it every cycle
    initial begin
        pixel_dataout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) pixel_dataout_ready = ~pixel_dataout_ready;
            else                 pixel_dataout_ready = 1'b1;
        end
    end

    // Scoreboard and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) check("rd_extra", 1, 0);
                else                        check("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
                outstanding++;
            end
            if (pixel_dataout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) check("hold", {pixel_dataout_valid, pixel_dataout}, {1'b1, prev_data});
            if (pixel_dataout_valid && pixel_dataout_ready) begin
                if (exp_q.size() == 0) check("pix_extra", 1, 0);
                else                   check("pixel", pixel_dataout, exp_q.pop_front());
                outstanding--;
                accepted++;
                last_xfer_cyc = cyc;
            end
            if (pixel_dataout_valid && !pixel_dataout_ready) stall_exp++;
            if (busy) check("outstanding_le2", 32'(outstanding <= 2), 1);
            if (done) done_cnt++;
            prev_stall = pixel_dataout_valid && !pixel_dataout_ready;
            prev_data  = pixel_dataout;
        end
    end

    task automatic start_frame(input logic [15:0] b, input logic [15:0] l);
        for (int i = 0; i < int'(l); i++) begin
            exp_addr_q.push_back(b + 16'(i));
            exp_q.push_back(ram_val(b + 16'(i)));
        end
        done_cnt        = 0;
        first_valid_cyc = -1;
        stall_exp       = 0;
        accepted        = 0;
        outstanding     = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        frame_len = l;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        base_addr = 16'($urandom_range(0, 16'hFFFF));
        frame_len = 16'($urandom_range(1, 16'hFFFF));
    endtask

    task automatic wait_frame(input int max_cyc);
        int n = 0;
        while (!(done_cnt > 0 && !busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", 32'(n < max_cyc), 1);
    endtask

    task automatic check_frame_end(input string tag, input int len);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_count"}, accepted, len);
        check({tag, "_pix_left"}, exp_q.size(), 0);
        check({tag, "_addr_left"}, exp_addr_q.size(), 0);
        check({tag, "_idle"}, {busy, done, pixel_dataout_valid}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_rd_addr"}, mem_rd_addr, 0);
        check({tag, "_data"}, pixel_dataout, 0);
        check({tag, "_valid"}, pixel_dataout_valid, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        frame_len = '0;
        #1;
        check_reset_outputs("rst0");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: four pixels back to back from 0x0010; first valid three cycles after the start cycle
        start_frame(16'h0010, 16'd4);
        wait_frame(50);
        check_frame_end("t1", 4);
        check("t1_first_valid", first_valid_cyc - start_cyc, 2);
        check("t1_back_to_back", last_xfer_cyc - first_valid_cyc, 3);

        // 2: eight pixels with ready toggling
        ready_mode = 1;
        start_frame(16'h0040, 16'd8);
        wait_frame(100);
        check_frame_end("t2", 8);
        check("t2_stalled", 32'(stall_exp > 0), 1);
`ifdef FEEDER_STALL_STATS_EN
        check("t2_stall_count", stall_count, stall_exp);
`endif
        ready_mode = 0;

        // 3: address wrap past the top of the RAM
        start_frame(16'hFFFE, 16'd4);
        wait_frame(50);
        check_frame_end("t3", 4);
`ifdef FEEDER_STALL_STATS_EN
        check("t3_stall_count", stall_count, 0);
`endif

        // 4: empty frame
        start_frame(16'h1234, 16'd0);
        wait_frame(5);
        check_frame_end("t4", 0);

        // 5: start while busy is ignored
        start_frame(16'h0300, 16'd6);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 16'h0500;
        frame_len = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_frame(50);
        check_frame_end("t5", 6);

        // 6: asynchronous reset after three accepted pixels, then a clean frame
        start_frame(16'h0100, 16'd8);
        n = 0;
        while (accepted < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach3", 32'(accepted >= 3), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt, 0);
        start_frame(16'h0200, 16'd5);
        wait_frame(50);
        check_frame_end("t6_clean", 5);
        check("t6_first_valid", first_valid_cyc - start_cyc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
